pixel_scheduler: RTL and testbench

PIXEL_SCHEDULER -- requirements
Module: pixel_scheduler

---
 rtl/pixel_scheduler.sv | 142 ++++++++++++++
 tb/tb_pixel_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_scheduler.sv
// Pixel/sample scheduler feeding a ray generator pipeline.
// Define PIXEL_SCHED_PERF_EN to add stall_cycles/issue_count outputs.
module pixel_scheduler #(
  parameter int PIXEL_WIDTH       = 800,
  parameter int PIXEL_HEIGHT      = 600,
  parameter int SAMPLES_PER_PIXEL = 4,
  parameter int GEN_LATENCY       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ds_ready,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [3:0]  sample_idx,
  output logic        stall,
  output logic        ray_valid,
  output logic        busy,
  output logic        frame_done
`ifdef PIXEL_SCHED_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] issue_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [9:0] XMAX = 10'(PIXEL_WIDTH - 1);
  localparam logic [9:0] YMAX = 10'(PIXEL_HEIGHT - 1);
  localparam logic [3:0] SMAX = 4'(SAMPLES_PER_PIXEL - 1);

  state_t state_q, state_d;
  logic [9:0] px_q, px_d;
  logic [9:0] py_q, py_d;
  logic [3:0] sx_q, sx_d;
  logic [GEN_LATENCY-1:0] vld_q, vld_d;
  logic issue;

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    sx_d    = sx_q;
    vld_d   = vld_q;
    stall   = 1'b1;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        stall = ~ds_ready;
        issue = ds_ready;
      end
      DRAIN: begin
        stall = ~ds_ready;
      end
      DONE: begin
        state_d = IDLE;
        px_d    = '0;
        py_d    = '0;
        sx_d    = '0;
      end
    endcase
    if (issue) begin
      if (sx_q == SMAX) begin
        sx_d = '0;
        if (px_q == XMAX) begin
          px_d = '0;
          if (py_q == YMAX) begin
            py_d    = '0;
            state_d = DRAIN;
          end else begin
            py_d = py_q + 10'd1;
          end
        end else begin
          px_d = px_q + 10'd1;
        end
      end else begin
        sx_d = sx_q + 4'd1;
      end
    end
    if (!stall) begin
      vld_d[0] = issue;
      for (int i = 1; i < GEN_LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end
    // leave DRAIN as the final ray is consumed
    if (state_q == DRAIN && vld_d == '0) state_d = DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      px_q    <= '0;
      py_q    <= '0;
      sx_q    <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      sx_q    <= sx_d;
      vld_q   <= vld_d;
    end
  end

  assign pixel_x    = px_q;
  assign pixel_y    = py_q;
  assign sample_idx = sx_q;
  assign ray_valid  = vld_q[GEN_LATENCY-1];
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign frame_done = (state_q == DONE);

`ifdef PIXEL_SCHED_PERF_EN
  logic [31:0] stc_q, isc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stc_q <= '0;
      isc_q <= '0;
    end else if (state_q == IDLE && start) begin
      stc_q <= '0;
      isc_q <= '0;
    end else begin
      if (busy && stall) stc_q <= stc_q + 32'd1;
      if (issue) isc_q <= isc_q + 32'd1;
    end
  end

  assign stall_cycles = stc_q;
  assign issue_count  = isc_q;
`endif

endmodule

// File: tb/tb_pixel_scheduler.sv
// Scoreboard bench for pixel_scheduler at 4x3, 2 samples,
// latency 4.
module tb_pixel_scheduler;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int S  = 2;
  localparam int GL = 4;
  localparam int N  = W * H * S;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic ds_ready = 1'b0;
  logic [9:0] pixel_x, pixel_y;
  logic [3:0] sample_idx;
  logic stall, ray_valid, busy, frame_done;
`ifdef PIXEL_SCHED_PERF_EN
  logic [31:0] stall_cycles, issue_count;
`endif

  pixel_scheduler #(
    .PIXEL_WIDTH(W),
    .PIXEL_HEIGHT(H),
    .SAMPLES_PER_PIXEL(S),
    .GEN_LATENCY(GL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .ds_ready(ds_ready),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .sample_idx(sample_idx),
    .stall(stall),
    .ray_valid(ray_valid),
    .busy(busy),
    .frame_done(frame_done)
`ifdef PIXEL_SCHED_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .issue_count(issue_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] s;
  } tup_t;

  int vectors = 0;
  int miscompares = 0;
  int ms;
  int m_issued;
  int m_stalls;
  logic [GL-1:0] m_pipe;
  int rays;
  int dones;
  tup_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    ms = 0;
    m_issued = 0;
    m_stalls = 0;
    m_pipe = '0;
    q.delete();
  endtask

  task automatic load_frame();
    tup_t t;
    q.delete();
    for (int i = 0; i < N; i++) begin
      t.x = 10'((i / S) % W);
      t.y = 10'(i / (S * W));
      t.s = 4'(i % S);
      q.push_back(t);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_x", 32'(pixel_x), 0);
    chk("rst_y", 32'(pixel_y), 0);
    chk("rst_s", 32'(sample_idx), 0);
    chk("rst_stall", 32'(stall), 1);
    chk("rst_rv", 32'(ray_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
`ifdef PIXEL_SCHED_PERF_EN
    chk("rst_stc", stall_cycles, 0);
    chk("rst_isc", issue_count, 0);
`endif
  endtask

  task automatic cyc(input logic rdy, input logic st);
    logic es, issue;
    logic [GL-1:0] nxt;
    tup_t t;
    @(negedge clk);
    ds_ready = rdy;
    start = st;
    #1;
    es = (ms == 0 || ms == 3) ? 1'b1 : !rdy;
    issue = (ms == 1) && rdy;
    chk("stall", 32'(stall), 32'(es));
    chk("busy", 32'(busy), 32'(ms == 1 || ms == 2));
    chk("frame_done", 32'(frame_done), 32'(ms == 3));
    chk("ray_valid", 32'(ray_valid), 32'(m_pipe[GL-1]));
    if (ms == 1) begin
      if (q.size() == 0) begin
        chk("queue_empty", 1, 0);
      end else begin
        t = q[0];
        chk("pixel_x", 32'(pixel_x), 32'(t.x));
        chk("pixel_y", 32'(pixel_y), 32'(t.y));
        chk("sample_idx", 32'(sample_idx), 32'(t.s));
        if (issue) void'(q.pop_front());
      end
    end else if (ms == 0) begin
      chk("idle_tuple", {8'd0, pixel_x, pixel_y, sample_idx}, 0);
    end
`ifdef PIXEL_SCHED_PERF_EN
    if (ms == 3) begin
      chk("issue_count", issue_count, 32'(N));
      chk("stall_cycles", stall_cycles, 32'(m_stalls));
    end
`endif
    if (ray_valid && rdy) rays++;
    if (frame_done) dones++;
    if ((ms == 1 || ms == 2) && !rdy) m_stalls++;
    nxt = m_pipe;
    if (!es) nxt = {m_pipe[GL-2:0], issue};
    case (ms)
      0: if (st) begin
        ms = 1;
        m_issued = 0;
        m_stalls = 0;
        load_frame();
      end
      1: if (issue) begin
        m_issued++;
        if (m_issued == N) ms = 2;
      end
      2: if (nxt == '0) ms = 3;
      default: ms = 0;
    endcase
    m_pipe = nxt;
  endtask

  task automatic run_frame(input int stall_at, input int stall_len,
                           input bit pulse_run, input bit pulse_done,
                           input int abort_at);
    int n;
    logic rdy, st;
    n = 0;
    cyc(1'b1, 1'b1);
    while (ms != 0 && n < 500) begin
      if (abort_at > 0 && ms == 1 && m_issued == abort_at) begin
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      rdy = !(n >= stall_at && n < stall_at + stall_len);
      st = (pulse_run && n == 5) || (pulse_done && ms == 3);
      cyc(rdy, st);
      n++;
    end
    if (n >= 500) chk("timeout", 1, 0);
    cyc(1'b1, 1'b0);
  endtask

  initial begin
    int r0, d0;
    reset_model();
    rays = 0;
    dones = 0;
    #2 rst = 1'b1;
    @(negedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    r0 = rays; d0 = dones;
    run_frame(1000, 0, 1'b0, 1'b0, 0);
    chk("plain_rays", 32'(rays - r0), 32'(N));
    chk("plain_dones", 32'(dones - d0), 1);

    r0 = rays; d0 = dones;
    run_frame(10, 5, 1'b0, 1'b0, 0);
    chk("stall_rays", 32'(rays - r0), 32'(N));
    chk("stall_dones", 32'(dones - d0), 1);

    r0 = rays; d0 = dones;
    run_frame(1000, 0, 1'b1, 1'b1, 0);
    chk("pulse_rays", 32'(rays - r0), 32'(N));
    chk("pulse_dones", 32'(dones - d0), 1);

    r0 = rays; d0 = dones;
    run_frame(1000, 0, 1'b0, 1'b0, 10);
    chk("abort_dones", 32'(dones - d0), 0);

    r0 = rays; d0 = dones;
    run_frame(7, 3, 1'b0, 1'b0, 0);
    chk("after_rays", 32'(rays - r0), 32'(N));
    chk("after_dones", 32'(dones - d0), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
